// File: rtl/cap_pkg.sv
// Shared capture-path definitions: resolution codes, frame dimensions, FSM states.
package cap_pkg;

    localparam int DIM_W = 11;

    localparam logic [1:0] RES_VGA  = 2'b00;
    localparam logic [1:0] RES_XGA  = 2'b01;
    localparam logic [1:0] RES_SXGA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_ACTIVE
    } state_t;

    function automatic logic [DIM_W-1:0] res_width(input logic [1:0] r);
        case (r)
            RES_XGA:  return DIM_W'(1024);
            RES_SXGA: return DIM_W'(1280);
            default:  return DIM_W'(640);
        endcase
    endfunction

    function automatic logic [DIM_W-1:0] res_height(input logic [1:0] r);
        case (r)
            RES_XGA:  return DIM_W'(768);
            RES_SXGA: return DIM_W'(1024);
            default:  return DIM_W'(480);
        endcase
    endfunction

endpackage

// File: rtl/cap_rgb565to888.sv
// RGB565 to RGB888 expansion; low bits replicate the channel MSBs.
module cap_rgb565to888 (
    input  logic [15:0] pix565,
    output logic [23:0] pix888
);

    assign pix888 = {pix565[15:11], pix565[15:13],
                     pix565[10:5],  pix565[10:9],
                     pix565[4:0],   pix565[4:2]};

endmodule

// File: rtl/cap_pixpack.sv
// Capture pixel packer: crops the camera stream to the selected window and
// packs RGB888 pixel pairs into 48-bit FIFO words.
module cap_pixpack
    import cap_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int OUT_W = 48,
    parameter int CNT_W = 11
) (
    input  logic             ACLK,
    input  logic             ARST,
    input  logic             PRST,
    input  logic [1:0]       RESOL,
    input  logic             CAP_EN,
    input  logic             PIX_VALID,
    input  logic [PIX_W-1:0] PIX_DATA,
    input  logic             PIX_SOF,
    input  logic             PIX_EOL,
    input  logic             FIFO_FULL,
    output logic             FIFO_WR,
    output logic [OUT_W-1:0] FIFO_DIN,
    output logic             FRAME_DONE,
    output logic             OVERFLOW,
    output logic             SYNC_ERR
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             rst;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic [CNT_W-1:0] w_q;
    logic [CNT_W-1:0] h_q;
    logic             pend_q;
    logic [23:0]      held_q;
    logic             wr_q;
    logic [OUT_W-1:0] dout_q;
    logic             done_q;
    logic             ovf_q;
    logic             serr_q;
    logic [23:0]      pix24;

    logic             sof_beat;
    logic             start;
    logic             resync;
    logic             beat;
    logic             take;
    logic             eol;
    logic             last;
    logic             emit;
    logic [OUT_W-1:0] word;

    assign rst = ARST | PRST;

    cap_rgb565to888 u_exp (
        .pix565 (PIX_DATA),
        .pix888 (pix24)
    );

    // SOF always wins over EOL on the same beat.
    assign sof_beat = PIX_VALID & PIX_SOF;
    assign start    = (state_q == ST_WAIT_SOF) & sof_beat;
    assign resync   = (state_q == ST_ACTIVE) & sof_beat;
    assign beat     = (state_q == ST_ACTIVE) & PIX_VALID & ~PIX_SOF;
    assign take     = beat & (x_q < w_q) & (y_q < h_q);
    assign eol      = beat & PIX_EOL;
    assign last     = eol & (y_q == h_q - ONE);

    always_ff @(posedge ACLK) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (CAP_EN) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (start) state_d = ST_ACTIVE;
            ST_ACTIVE:   if (last) state_d = CAP_EN ? ST_WAIT_SOF : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // A word leaves on the odd pixel, or padded when a line ends on an even one.
    always_comb begin
        emit = 1'b0;
        word = '0;
        if (take & pend_q) begin
            emit = 1'b1;
            word = {pix24, held_q};
        end else if (eol & take) begin
            emit = 1'b1;
            word = {24'h0, pix24};
        end
    end

    always_ff @(posedge ACLK) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= CNT_W'(res_width(RES_VGA));
            h_q    <= CNT_W'(res_height(RES_VGA));
            pend_q <= 1'b0;
            held_q <= '0;
            wr_q   <= 1'b0;
            dout_q <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            if (state_q != ST_ACTIVE) begin
                w_q <= CNT_W'(res_width(RESOL));
                h_q <= CNT_W'(res_height(RESOL));
            end
            wr_q <= emit;
            if (emit) dout_q <= word;
            done_q <= last;
            ovf_q  <= ovf_q | (wr_q & FIFO_FULL);
            serr_q <= serr_q | resync;
            if (start | resync) begin
                x_q    <= ONE;
                y_q    <= '0;
                held_q <= pix24;
                pend_q <= 1'b1;
            end else if (beat) begin
                if (take) begin
                    x_q    <= x_q + ONE;
                    held_q <= pix24;
                    pend_q <= ~pend_q;
                end
                if (PIX_EOL) begin
                    x_q    <= '0;
                    pend_q <= 1'b0;
                    if (y_q != h_q) y_q <= y_q + ONE;
                end
            end
        end
    end

    assign FIFO_WR    = wr_q & ~FIFO_FULL;
    assign FIFO_DIN   = dout_q;
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;
    assign SYNC_ERR   = serr_q;

endmodule

// File: tb/tb_cap_pixpack.sv
// Self-checking bench for cap_pixpack: vector table, directed corner cases
// and randomized frames against a line-level packing model.
module tb_cap_pixpack;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        PRST;
    logic [1:0]  RESOL;
    logic        CAP_EN;
    logic        PIX_VALID;
    logic [15:0] PIX_DATA;
    logic        PIX_SOF;
    logic        PIX_EOL;
    logic        FIFO_FULL;
    logic        FIFO_WR;
    logic [47:0] FIFO_DIN;
    logic        FRAME_DONE;
    logic        OVERFLOW;
    logic        SYNC_ERR;

    always #5 ACLK = ~ACLK;

    cap_pixpack dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .PRST       (PRST),
        .RESOL      (RESOL),
        .CAP_EN     (CAP_EN),
        .PIX_VALID  (PIX_VALID),
        .PIX_DATA   (PIX_DATA),
        .PIX_SOF    (PIX_SOF),
        .PIX_EOL    (PIX_EOL),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WR    (FIFO_WR),
        .FIFO_DIN   (FIFO_DIN),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW),
        .SYNC_ERR   (SYNC_ERR)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [47:0] got_q[$];
    logic [47:0] exp_q[$];
    logic [15:0] line_q[$];

    always @(negedge ACLK) begin
        if (FIFO_WR) got_q.push_back(FIFO_DIN);
        if (FRAME_DONE) done_cnt++;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [47:0] w;
    } vec_t;

    vec_t tv[5];

    function automatic logic [23:0] exp24(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return 24'(((r * 8 + r / 4) << 16) + ((g * 4 + g / 16) << 8)
                   + (b * 8 + b / 4));
    endfunction

    function automatic int width_of(input logic [1:0] r);
        case (r)
            2'b01:   return 1024;
            2'b10:   return 1280;
            default: return 640;
        endcase
    endfunction

    function automatic int height_of(input logic [1:0] r);
        case (r)
            2'b01:   return 768;
            2'b10:   return 1024;
            default: return 480;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d,
                       input logic s, input logic e);
        PIX_VALID = v;
        PIX_DATA  = d;
        PIX_SOF   = s;
        PIX_EOL   = e;
        @(posedge ACLK);
        #1;
        PIX_VALID = 1'b0;
        PIX_SOF   = 1'b0;
        PIX_EOL   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic mk_line(input int n);
        line_q.delete();
        repeat (n) line_q.push_back(16'($urandom));
    endtask

    // Expected words of one line: first w pixels in pairs, odd tail zero-padded.
    task automatic model_line(input int w);
        int n;
        logic [23:0] lo, hi;
        n = (line_q.size() < w) ? line_q.size() : w;
        for (int i = 0; i < n; i += 2) begin
            lo = exp24(line_q[i]);
            hi = (i + 1 < n) ? exp24(line_q[i + 1]) : 24'h0;
            exp_q.push_back({hi, lo});
        end
    endtask

    task automatic send_line(input bit sof, input bit eol, input bit gaps);
        int n;
        n = line_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            cyc(1'b1, line_q[i], sof && i == 0, eol && i == n - 1);
        end
    endtask

    task automatic cmp_words(input string nm);
        idle(3);
        chk($sformatf("%s count", nm), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s word %0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
            if (got_q[i] !== exp_q[i]) break;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0, w, h, len;
        logic [1:0] r;
        logic [15:0] a, b, c, d;

        tv[0] = '{16'hF800, 16'h07E0, 48'h00FF00_FF0000};
        tv[1] = '{16'h001F, 16'hFFFF, 48'hFFFFFF_0000FF};
        tv[2] = '{16'h0000, 16'h8410, 48'h848284_000000};
        tv[3] = '{16'h1234, 16'h4208, 48'h424142_1045A5};
        tv[4] = '{16'hFFFF, 16'h0000, 48'h000000_FFFFFF};

        ARST = 1'b1;
        PRST = 1'b0;
        RESOL = 2'b00;
        CAP_EN = 1'b0;
        PIX_VALID = 1'b0;
        PIX_DATA = '0;
        PIX_SOF = 1'b0;
        PIX_EOL = 1'b0;
        FIFO_FULL = 1'b0;
        idle(3);
        chk("rst FIFO_WR", 64'(FIFO_WR), 64'd0);
        chk("rst FIFO_DIN", 64'(FIFO_DIN), 64'd0);
        chk("rst FRAME_DONE", 64'(FRAME_DONE), 64'd0);
        chk("rst OVERFLOW", 64'(OVERFLOW), 64'd0);
        chk("rst SYNC_ERR", 64'(SYNC_ERR), 64'd0);
        ARST = 1'b0;
        CAP_EN = 1'b1;
        idle(2);

        // expansion / pairing / latency-1 table, frame starts on first beat
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, tv[i].a, i == 0, 1'b0);
            chk($sformatf("tbl%0d wr after even", i), 64'(FIFO_WR), 64'd0);
            cyc(1'b1, tv[i].b, 1'b0, 1'b0);
            chk($sformatf("tbl%0d wr", i), 64'(FIFO_WR), 64'd1);
            chk($sformatf("tbl%0d din", i), 64'(FIFO_DIN), 64'(tv[i].w));
        end
        idle(1);
        got_q.delete();
        exp_q.delete();

        mk_line(3);
        model_line(640);
        send_line(1'b0, 1'b1, 1'b0);
        cmp_words("short line");

        mk_line(700);
        model_line(640);
        send_line(1'b0, 1'b1, 1'b1);
        cmp_words("long line");

        a = 16'($urandom);
        b = 16'($urandom);
        c = 16'($urandom);
        d = 16'($urandom);
        cyc(1'b1, a, 1'b0, 1'b0);
        cyc(1'b1, b, 1'b0, 1'b0);
        FIFO_FULL = 1'b1;
        #1;
        chk("full blocks wr", 64'(FIFO_WR), 64'd0);
        idle(1);
        FIFO_FULL = 1'b0;
        chk("overflow set", 64'(OVERFLOW), 64'd1);
        cyc(1'b1, c, 1'b0, 1'b0);
        cyc(1'b1, d, 1'b0, 1'b1);
        exp_q.push_back({exp24(d), exp24(c)});
        cmp_words("after overflow");

        // finish the VGA frame with short lines (y is 3 now)
        d0 = done_cnt;
        for (int l = 3; l < 479; l++) begin
            mk_line($urandom_range(1, 5));
            model_line(640);
            send_line(1'b0, 1'b1, 1'b0);
        end
        chk("no early done", 64'(done_cnt - d0), 64'd0);
        mk_line(3);
        model_line(640);
        send_line(1'b0, 1'b1, 1'b0);
        chk("done pulse", 64'(FRAME_DONE), 64'd1);
        idle(1);
        chk("done one cycle", 64'(FRAME_DONE), 64'd0);
        mk_line(4);
        send_line(1'b0, 1'b1, 1'b0);
        cmp_words("vga frame");
        chk("done count", 64'(done_cnt - d0), 64'd1);
        chk("no sync err", 64'(SYNC_ERR), 64'd0);
        chk("overflow sticky", 64'(OVERFLOW), 64'd1);

        for (int f = 0; f < 3; f++) begin
            r = 2'($urandom_range(0, 3));
            RESOL = r;
            idle(2);
            w = width_of(r);
            h = height_of(r);
            d0 = done_cnt;
            for (int l = 0; l < h; l++) begin
                case ($urandom_range(0, 399))
                    0:       len = w + $urandom_range(0, 6);
                    1:       len = w;
                    default: len = $urandom_range(l == 0 ? 2 : 1, 6);
                endcase
                mk_line(len);
                model_line(w);
                send_line(l == 0, 1'b1, 1'b1);
            end
            cmp_words($sformatf("rand frame %0d", f));
            chk($sformatf("rand done %0d", f), 64'(done_cnt - d0), 64'd1);
        end

        // SOF arriving mid-line restarts the frame; the odd pending pixel is lost
        RESOL = 2'b00;
        idle(2);
        d0 = done_cnt;
        for (int l = 0; l < 10; l++) begin
            mk_line(2);
            model_line(640);
            send_line(l == 0, 1'b1, 1'b0);
        end
        mk_line(101);
        send_line(1'b0, 1'b0, 1'b0);
        void'(line_q.pop_back());
        model_line(640);
        chk("sync err before", 64'(SYNC_ERR), 64'd0);
        for (int l = 0; l < 479; l++) begin
            mk_line($urandom_range(2, 4));
            model_line(640);
            send_line(l == 0, 1'b1, 1'b0);
            if (l == 0) chk("sync err set", 64'(SYNC_ERR), 64'd1);
        end
        chk("no done after resync", 64'(done_cnt - d0), 64'd0);
        mk_line(2);
        model_line(640);
        send_line(1'b0, 1'b1, 1'b0);
        cmp_words("resync frame");
        chk("resync done", 64'(done_cnt - d0), 64'd1);

        // camera reset mid-line, with a completing beat in the same cycle
        chk("overflow before prst", 64'(OVERFLOW), 64'd1);
        cyc(1'b1, 16'($urandom), 1'b1, 1'b0);
        CAP_EN = 1'b0;
        PRST = 1'b1;
        cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        PRST = 1'b0;
        chk("prst FIFO_WR", 64'(FIFO_WR), 64'd0);
        chk("prst FIFO_DIN", 64'(FIFO_DIN), 64'd0);
        chk("prst FRAME_DONE", 64'(FRAME_DONE), 64'd0);
        chk("prst OVERFLOW", 64'(OVERFLOW), 64'd0);
        chk("prst SYNC_ERR", 64'(SYNC_ERR), 64'd0);
        mk_line(2);
        send_line(1'b1, 1'b1, 1'b0);
        cmp_words("idle ignores");
        CAP_EN = 1'b1;
        idle(2);
        mk_line(2);
        model_line(640);
        send_line(1'b1, 1'b1, 1'b0);
        cmp_words("after prst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
